// File: rtl/uart_rx_if.sv
// Serial input and byte-output side of the UART receiver.
// The slave side is the receiver. The master side drives the line and consumes the bytes.
interface uart_rx_if;
  logic       uart_rxd;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_frame_err;

  modport slave (
    input  uart_rxd,
    output rx_data,
    output rx_done,
    output rx_frame_err
  );

  modport master (
    output uart_rxd,
    input  rx_data,
    input  rx_done,
    input  rx_frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver. The line passes through a two-flop synchroniser.
// Each bit is sampled once at its nominal centre, using the transmitter's clock-per-bit divider.
module uart_rx #(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 100000
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for a falling edge on the synchronised line
  // START | timing the start bit; abandoned at mid-bit if the line is high again
  // RECV  | sampling 8 data bits at their centres, LSB first
  // STOP  | checking the stop bit at mid-bit, then publishing or flagging the byte
  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam logic [31:0] LAST = 32'(DIV - 1);
  localparam logic [31:0] MID  = 32'(DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, RECV, STOP} state_t;

  state_t      state;
  logic        rxd_m, rxd_s, rxd_p;
  logic [31:0] count;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift;
  logic [7:0]  rx_data_q;
  logic        rx_done_q;
  logic        rx_frame_err_q;

  assign bus.rx_data      = rx_data_q;
  assign bus.rx_done      = rx_done_q;
  assign bus.rx_frame_err = rx_frame_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_m          <= 1'b1;
      rxd_s          <= 1'b1;
      rxd_p          <= 1'b1;
      state          <= IDLE;
      count          <= '0;
      bit_cnt        <= '0;
      shift          <= '0;
      rx_data_q      <= '0;
      rx_done_q      <= 1'b0;
      rx_frame_err_q <= 1'b0;
    end else begin
      rxd_m          <= bus.uart_rxd;
      rxd_s          <= rxd_m;
      rxd_p          <= rxd_s;
      rx_done_q      <= 1'b0;
      rx_frame_err_q <= 1'b0;

      if (state == IDLE || count == LAST)
        count <= '0;
      else
        count <= count + 32'd1;

      if (state != RECV)
        bit_cnt <= '0;
      else if (count == LAST)
        bit_cnt <= bit_cnt + 4'd1;

      case (state)
        IDLE: begin
          // Edge rather than level, so a held-low break cannot retrigger.
          if (!rxd_s && rxd_p)
            state <= START;
        end
        START: begin
          if (count == MID && rxd_s)
            state <= IDLE;
          else if (count == LAST)
            state <= RECV;
        end
        RECV: begin
          if (count == MID)
            shift[bit_cnt[2:0]] <= rxd_s;
          if (count == LAST && bit_cnt == 4'd7)
            state <= STOP;
        end
        STOP: begin
          // Leave at mid-bit so that half a bit of margin remains for a back-to-back start.
          if (count == MID) begin
            state <= IDLE;
            if (rxd_s) begin
              rx_data_q <= shift;
              rx_done_q <= 1'b1;
            end else begin
              rx_frame_err_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. The frame model predicts each byte and framing error,
// and the clock cycle on which it must be reported.
module tb_uart_rx;
  localparam int DIV    = 10;
  localparam int OFFSET = 3 + 9 * DIV + DIV / 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic last_edge_rst = 1'b1;
  logic [7:0] prev_data = '0;

  int         done_cyc_q[$];
  logic [7:0] done_dat_q[$];
  int         err_cyc_q[$];
  int         exp_done_cyc[$];
  logic [7:0] exp_done_dat[$];
  int         exp_err_cyc[$];

  uart_rx_if bus();

  uart_rx #(.CLK_FREQ(1000000), .BAUD_RATE(100000)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc           <= cyc + 1;
    last_edge_rst <= rst;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Event recorder, plus the invariants that hold on every cycle.
  always @(negedge clk) begin
    if (last_edge_rst) begin
      prev_data = bus.rx_data;
    end else begin
      if (bus.rx_done === 1'b1 && bus.rx_frame_err === 1'b1)
        chk("done_and_err_together", 32'd1, 32'd0);
      if (bus.rx_data !== prev_data)
        chk("data_change_without_done", {31'd0, bus.rx_done}, 32'd1);
      if (bus.rx_done === 1'b1) begin
        done_cyc_q.push_back(cyc);
        done_dat_q.push_back(bus.rx_data);
      end
      if (bus.rx_frame_err === 1'b1)
        err_cyc_q.push_back(cyc);
      prev_data = bus.rx_data;
    end
  end

  // Must be called at a negedge. Each bit is held for DIV clocks, so frames sent in succession have no gap.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit track);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    if (track) begin
      if (stop) begin
        exp_done_cyc.push_back(cyc + OFFSET);
        exp_done_dat.push_back(b);
      end else begin
        exp_err_cyc.push_back(cyc + OFFSET);
      end
    end
    for (int i = 0; i < 10; i++) begin
      bus.uart_rxd = bits[i];
      repeat (DIV) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    bus.uart_rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic compare_events(input string tag);
    int n;
    chk({tag, "_ndone"}, done_cyc_q.size(), exp_done_cyc.size());
    chk({tag, "_nerr"}, err_cyc_q.size(), exp_err_cyc.size());
    n = (done_cyc_q.size() < exp_done_cyc.size()) ? done_cyc_q.size() : exp_done_cyc.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_done_cyc"}, done_cyc_q[i], exp_done_cyc[i]);
      chk({tag, "_done_dat"}, {24'd0, done_dat_q[i]}, {24'd0, exp_done_dat[i]});
    end
    n = (err_cyc_q.size() < exp_err_cyc.size()) ? err_cyc_q.size() : exp_err_cyc.size();
    for (int i = 0; i < n; i++)
      chk({tag, "_err_cyc"}, err_cyc_q[i], exp_err_cyc[i]);
    done_cyc_q.delete();
    done_dat_q.delete();
    err_cyc_q.delete();
    exp_done_cyc.delete();
    exp_done_dat.delete();
    exp_err_cyc.delete();
  endtask

  initial begin
    logic [7:0] b;
    int         c_first;

    bus.uart_rxd = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("rst_data", {24'd0, bus.rx_data}, 32'd0);
    chk("rst_done", {31'd0, bus.rx_done}, 32'd0);
    chk("rst_err", {31'd0, bus.rx_frame_err}, 32'd0);
    rst = 1'b0;
    idle(5);
    chk("post_rst_done", {31'd0, bus.rx_done}, 32'd0);

    send_frame(8'hA5, 1'b1, 1'b1);
    idle(30);
    compare_events("single");
    chk("single_data", {24'd0, bus.rx_data}, 32'h0000_00A5);

    c_first = cyc + OFFSET;
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'h5A, 1'b1, 1'b1);
    send_frame(8'h81, 1'b1, 1'b1);
    idle(30);
    if (done_cyc_q.size() == 4)
      for (int i = 1; i < 4; i++)
        chk("b2b_spacing", done_cyc_q[i] - done_cyc_q[i-1], 10 * DIV);
    chk("b2b_first_cyc", (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1, c_first);
    compare_events("b2b");
    chk("b2b_data", {24'd0, bus.rx_data}, 32'h0000_0081);

    send_frame(8'h3C, 1'b0, 1'b1);
    bus.uart_rxd = 1'b0;
    repeat (300) @(negedge clk);
    idle(50);
    compare_events("frame_err");
    chk("frame_err_data_kept", {24'd0, bus.rx_data}, 32'h0000_0081);

    bus.uart_rxd = 1'b0;
    repeat (3) @(negedge clk);
    idle(20);
    send_frame(8'h42, 1'b1, 1'b1);
    idle(30);
    compare_events("false_start");
    chk("false_start_data", {24'd0, bus.rx_data}, 32'h0000_0042);

    for (int k = 0; k < 256; k++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, 1'b1);
      if ($urandom_range(0, 3) == 0)
        idle($urandom_range(1, 7));
    end
    idle(30);
    compare_events("loopback");

    // The line stays high after the reset, so the rest of the frame shows no falling edge.
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        repeat (45) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    join
    idle(100);
    compare_events("mid_reset");
    chk("mid_reset_data", {24'd0, bus.rx_data}, 32'd0);
    send_frame(8'h6B, 1'b1, 1'b1);
    idle(30);
    compare_events("after_reset");
    chk("after_reset_data", {24'd0, bus.rx_data}, 32'h0000_006B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that deserialises an 8N1 serial stream (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) into bytes. It sits directly downstream of the team's UART transmitter and consumes its serial line output in loopback tests and on the board. The input is asynchronous and is synchronised internally. Each bit is sampled once at its nominal centre using the same clock-per-bit divider as the transmitter.

## Interface
- CLK_FREQ, 1000000, system clock frequency in Hz
- BAUD_RATE, 100000, serial bit rate in baud
- DIV, CLK_FREQ / BAUD_RATE (10), clocks per bit; must be ≥ 4 and even
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- uart_rxd  input  1  serial line, asynchronous, idles high
- rx_data  output  8  last correctly framed byte, held until the next valid byte
- rx_done  output  1  one-cycle pulse: rx_data has just been updated
- rx_frame_err  output  1  one-cycle pulse: stop bit sampled low, byte discarded

## Operation
- Synchroniser: two flops, rxd_m then rxd_s, plus rxd_p, which is rxd_s delayed one cycle. All three reset to 1.
- Start detect: rxd_s == 0 && rxd_p == 1, an edge rather than a level, so a held-low line (break) cannot retrigger.
- Counters:
  - count is 32-bit. It runs 0..DIV-1 in every non-IDLE state, wraps to 0 at DIV-1, and is forced to 0 in IDLE.
  - bit_cnt is 4-bit. It increments in RECV when count == DIV-1 and is forced to 0 outside RECV.
- Mid-bit point: count == DIV/2-1.
- FSM states: IDLE, START, RECV, STOP.
  - IDLE → START on start detect.
  - START at the mid-bit point:
    - rxd_s == 1 → IDLE (false start); no outputs change.
    - rxd_s == 0 → stay in START until count == DIV-1, then → RECV.
  - RECV:
    - At the mid-bit point, shift[bit_cnt] <= rxd_s.
    - At count == DIV-1 with bit_cnt == 7 → STOP.
  - STOP at the mid-bit point → IDLE, and:
    - rxd_s == 1: rx_data <= shift, rx_done <= 1.
    - rxd_s == 0: rx_frame_err <= 1; rx_data unchanged.
- Leaving STOP at mid-bit leaves half a bit of margin to catch a back-to-back start edge.
- rx_done and rx_frame_err are never high together. Each is high for exactly one cycle.
- Reset has priority over everything:
  - FSM → IDLE.
  - count, bit_cnt, shift, rx_data → 0.
  - rx_done, rx_frame_err → 0.
  - Synchroniser flops → 1.
- Reset mid-frame abandons the byte. The rest of that frame must not produce rx_done, because the receiver only rearms on a falling edge. Low bits in the frame tail can falsely retrigger; this is accepted.

## Timing
- Edge numbering: edge 1 is the first rising clk edge that captures uart_rxd = 0 into rxd_m.
  - Edge 2: rxd_s = 0 and start is detected.
  - Edge 3: state = START, count = 0.
- Generally, count = k after edge 3 + k + DIV·(bit index).
- Data bit i is sampled at edge 3 + (i+1)·DIV + DIV/2.
- STOP is entered at edge 3 + 9·DIV.
- rx_done or rx_frame_err is high after edge 3 + 9·DIV + DIV/2. With DIV = 10 this is edge 98, and the pulse lasts exactly until edge 99.
- The state is IDLE on the same edge as the pulse. The next start edge is accepted immediately.
- rx_data changes only on the edge that raises rx_done.
- A false start with a glitch shorter than DIV/2 cycles returns to IDLE at edge 3 + DIV/2.

## Test plan
- Reset: hold rst 3 cycles with uart_rxd = 1 → rx_data = 0x00, rx_done = 0, rx_frame_err = 0, FSM in IDLE.
- Single byte: drive 0xA5 as 8N1 at DIV = 10, starting with a low at edge 1 → rx_done is a single pulse after edge 98, rx_data = 0xA5, rx_frame_err stays 0.
- Back-to-back: send 0x00, 0xFF, 0x5A, 0x81 with no idle gap → four rx_done pulses exactly 10·DIV cycles apart, with the correct bytes in order.
- Framing error: send 0x3C with the stop bit driven low → rx_frame_err pulses at edge 98, rx_done stays 0, rx_data keeps its previous value. The line then held low (break) produces no further pulses.
- False start: a 3-cycle low glitch on an idle line → no rx_done and no rx_frame_err. A valid 0x42 sent 20 cycles later is received correctly.
- Loopback and reset: connect the transmitter's serial output to uart_rxd with matching DIV, send 256 random bytes → every byte matches, and each rx_done follows the transmitter's completion. Asserting rst for one cycle mid-byte → no rx_done for that byte, and the next full byte is received correctly.
